// File: rtl/approx_err_sweeper_if.sv
// Bus between the error sweeper and the exact/approximate circuit pair under evaluation.
// ERR_SWEEP_SUM_EN adds the err_sum result word.
interface approx_err_sweeper_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3
);
  logic               start;
  logic [IN_W-1:0]    vec_out;
  logic [OUT_W-1:0]   exact_in;
  logic [OUT_W-1:0]   approx_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [OUT_W-1:0]   max_err;
  logic [IN_W:0]      fail_count;
  logic [IN_W-1:0]    first_fail_vec;
  logic               first_fail_valid;
`ifdef ERR_SWEEP_SUM_EN
  logic [OUT_W+IN_W-1:0] err_sum;
`endif

  // Sweeper side: drives vectors and results, reads the circuit outputs.
  modport master (
`ifdef ERR_SWEEP_SUM_EN
    output err_sum,
`endif
    input  start, exact_in, approx_in,
    output vec_out, busy, done, pass, max_err, fail_count,
           first_fail_vec, first_fail_valid
  );

  // Environment side: the circuits under test plus whoever starts the sweep.
  modport slave (
`ifdef ERR_SWEEP_SUM_EN
    input  err_sum,
`endif
    output start, exact_in, approx_in,
    input  vec_out, busy, done, pass, max_err, fail_count,
           first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/approx_err_sweeper.sv
// Exhaustive error sweeper: drives all 2^IN_W vectors, tracks max abs error and failures above ET.
// Optional ERR_SWEEP_SUM_EN adds a running sum of all per-vector errors.
module approx_err_sweeper #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int ET    = 2
) (
  input  logic clk,
  input  logic rst,
  approx_err_sweeper_if.master bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  localparam logic [IN_W-1:0] LAST_VEC = '1;
  localparam logic [31:0]     ET_U     = 32'(ET);

  state_t             r_state;
  state_t             w_nextState;
  logic               w_startAccept;
  logic               w_busy;
  logic               w_done;

  logic [IN_W-1:0]    r_vec;
  logic [OUT_W-1:0]   r_diff;
  logic               r_valid;
  logic [IN_W-1:0]    r_tag;

  logic [OUT_W-1:0]   r_maxErr;
  logic [IN_W:0]      r_failCount;
  logic [IN_W-1:0]    r_firstFailVec;
  logic               r_firstFailValid;
  logic               r_pass;

  logic [OUT_W-1:0]   w_absDiff;
  logic               w_vecFails;
  logic [IN_W:0]      w_failCountNext;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // start is only honoured in IDLE, so holding it high never queues a second sweep.
  always_comb begin
    w_nextState   = r_state;
    w_startAccept = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextState   = SWEEP;
          w_startAccept = 1'b1;
        end
      end
      SWEEP: begin
        w_busy = 1'b1;
        if (r_vec == LAST_VEC) w_nextState = DRAIN;
      end
      DRAIN: begin
        w_busy      = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    if (bus.exact_in >= bus.approx_in) w_absDiff = bus.exact_in - bus.approx_in;
    else                               w_absDiff = bus.approx_in - bus.exact_in;
  end

  // Sample stage: the circuits see r_vec for a full cycle, the error is captured on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec   <= '0;
      r_diff  <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_startAccept) begin
        r_vec <= '0;
      end else if (r_state == SWEEP) begin
        r_diff  <= w_absDiff;
        r_valid <= 1'b1;
        r_tag   <= r_vec;
        r_vec   <= r_vec + 1'b1;
      end
    end
  end

  assign w_vecFails      = r_valid && (32'(r_diff) > ET_U);
  assign w_failCountNext = r_failCount + (IN_W+1)'(w_vecFails);

  // Accumulate stage; pass is taken from the count including the last vector, which lands in DRAIN.
  always_ff @(posedge clk) begin
    if (rst || w_startAccept) begin
      r_maxErr         <= '0;
      r_failCount      <= '0;
      r_firstFailVec   <= '0;
      r_firstFailValid <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      if (r_valid && (r_diff > r_maxErr)) r_maxErr <= r_diff;
      if (w_vecFails) begin
        r_failCount <= w_failCountNext;
        if (!r_firstFailValid) begin
          r_firstFailVec   <= r_tag;
          r_firstFailValid <= 1'b1;
        end
      end
      if (r_state == DRAIN) r_pass <= (w_failCountNext == '0);
    end
  end

`ifdef ERR_SWEEP_SUM_EN
  logic [OUT_W+IN_W-1:0] r_errSum;

  always_ff @(posedge clk) begin
    if (rst || w_startAccept) r_errSum <= '0;
    else if (r_valid)         r_errSum <= r_errSum + (OUT_W+IN_W)'(r_diff);
  end

  assign bus.err_sum = r_errSum;
`endif

  assign bus.vec_out          = r_vec;
  assign bus.busy             = w_busy;
  assign bus.done             = w_done;
  assign bus.pass             = r_pass;
  assign bus.max_err          = r_maxErr;
  assign bus.fail_count       = r_failCount;
  assign bus.first_fail_vec   = r_firstFailVec;
  assign bus.first_fail_valid = r_firstFailValid;

endmodule

// File: tb/tb_approx_err_sweeper.sv
// Self-checking bench for approx_err_sweeper: table-driven circuit models, directed and random sweeps.
// Build with ERR_SWEEP_SUM_EN defined to also check err_sum.
module tb_approx_err_sweeper;

  localparam int IN_W  = 4;
  localparam int OUT_W = 3;
  localparam int ET    = 2;
  localparam int NVEC  = 1 << IN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [OUT_W-1:0] tblE [NVEC];
  logic [OUT_W-1:0] tblA [NVEC];

  int expMax, expCount, expFirst, expFirstValid, expSum, expPass;

  approx_err_sweeper_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

  approx_err_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // The two circuits under evaluation are lookup tables indexed by the driven vector.
  always_comb begin
    bus.exact_in  = tblE[bus.vec_out];
    bus.approx_in = tblA[bus.vec_out];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic computeModel();
    int d;
    expMax = 0; expCount = 0; expFirst = 0; expFirstValid = 0; expSum = 0;
    for (int k = 0; k < NVEC; k++) begin
      d = int'(tblE[k]) - int'(tblA[k]);
      if (d < 0) d = -d;
      expSum += d;
      if (d > expMax) expMax = d;
      if (d > ET) begin
        expCount++;
        if (expFirstValid == 0) begin
          expFirst      = k;
          expFirstValid = 1;
        end
      end
    end
    expPass = (expCount == 0) ? 1 : 0;
  endtask

  task automatic applyStimulus(input int mode);
    for (int k = 0; k < NVEC; k++) begin
      case (mode)
        0: begin tblE[k] = OUT_W'(k); tblA[k] = OUT_W'(k); end
        1: begin tblE[k] = OUT_W'(k); tblA[k] = '0; end
        2: begin tblE[k] = '0; tblA[k] = (k == 9) ? OUT_W'(3) : '0; end
        default: begin
          tblE[k] = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
          tblA[k] = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
        end
      endcase
    end
    computeModel();
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, ".pass"},       32'(bus.pass), 32'(expPass));
    checkOutput({tag, ".max_err"},    32'(bus.max_err), 32'(expMax));
    checkOutput({tag, ".fail_count"}, 32'(bus.fail_count), 32'(expCount));
    checkOutput({tag, ".ffValid"},    32'(bus.first_fail_valid), 32'(expFirstValid));
    checkOutput({tag, ".ffVec"},      32'(bus.first_fail_vec), 32'(expFirst));
`ifdef ERR_SWEEP_SUM_EN
    checkOutput({tag, ".err_sum"},    32'(bus.err_sum), 32'(expSum));
`endif
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".vec_out"},    32'(bus.vec_out), 0);
    checkOutput({tag, ".busy"},       32'(bus.busy), 0);
    checkOutput({tag, ".done"},       32'(bus.done), 0);
    checkOutput({tag, ".pass"},       32'(bus.pass), 0);
    checkOutput({tag, ".max_err"},    32'(bus.max_err), 0);
    checkOutput({tag, ".fail_count"}, 32'(bus.fail_count), 0);
    checkOutput({tag, ".ffVec"},      32'(bus.first_fail_vec), 0);
    checkOutput({tag, ".ffValid"},    32'(bus.first_fail_valid), 0);
`ifdef ERR_SWEEP_SUM_EN
    checkOutput({tag, ".err_sum"},    32'(bus.err_sum), 0);
`endif
  endtask

  // One start pulse; cycle n is the negedge following the n-th rising edge after acceptance.
  task automatic runSweep(input string tag);
    int cycles, doneAt, busyLow;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    checkOutput({tag, ".busyStart"}, 32'(bus.busy), 1);
    cycles = 0; doneAt = -1; busyLow = 0;
    while (doneAt < 0 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (bus.done) doneAt = cycles;
      else if (!bus.busy) busyLow++;
    end
    checkOutput({tag, ".doneAt"}, 32'(doneAt), 17);
    checkOutput({tag, ".busyLowInSweep"}, 32'(busyLow), 0);
    checkOutput({tag, ".busyAtDone"}, 32'(bus.busy), 0);
    checkResults(tag);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, 32'(bus.done), 0);
    repeat (3) @(negedge clk);
    checkResults({tag, ".hold"});
  endtask

  initial begin
    int doneCount, firstDone, secondDone, sawFive, extraDone;
    bus.start = 1'b0;
    applyStimulus(0);

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    applyStimulus(0);
    runSweep("equal");
    applyStimulus(1);
    checkOutput("model.mode1Sum", 32'(expSum), 56);
    runSweep("vecVsZero");
    applyStimulus(2);
    runSweep("single9");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(3);
      runSweep($sformatf("rand%0d", r));
    end

    // Reset in the middle of a sweep.
    applyStimulus(1);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    sawFive = 0;
    for (int i = 0; i < 30 && sawFive == 0; i++) begin
      if (bus.vec_out == IN_W'(5)) sawFive = 1;
      else @(negedge clk);
    end
    checkOutput("midRst.reachedVec5", 32'(sawFive), 1);
    checkOutput("midRst.maxBefore", 32'(bus.max_err), 3);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("midRst");
    rst = 1'b0;
    extraDone = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) extraDone++;
    end
    checkOutput("midRst.quietAfter", 32'(extraDone), 0);
    runSweep("afterRst");

    // Start and reset together: reset wins.
    @(negedge clk) begin bus.start = 1'b1; rst = 1'b1; end
    @(negedge clk);
    checkOutput("startRst.busy", 32'(bus.busy), 0);
    checkOutput("startRst.max_err", 32'(bus.max_err), 0);
    bus.start = 1'b0; rst = 1'b0;
    @(negedge clk);
    checkOutput("startRst.idle", 32'(bus.busy), 0);

    // start held high: one sweep, then a second only after returning to IDLE.
    applyStimulus(3);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk);
    doneCount = 0; firstDone = -1; secondDone = -1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.done) begin
        doneCount++;
        if (firstDone < 0) firstDone = c;
        else if (secondDone < 0) secondDone = c;
      end
      if (c == 36) bus.start = 1'b0;
    end
    checkOutput("held.doneCount", 32'(doneCount), 2);
    checkOutput("held.firstDone", 32'(firstDone), 17);
    checkOutput("held.secondDone", 32'(secondDone), 36);
    checkOutput("held.idleAfter", 32'(bus.busy), 0);
    checkResults("held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
